mul_share_arb: RTL and testbench



---
 rtl/mul_share_arb_pkg.sv | 22 ++
 rtl/mul_share_arb_rr_pick.sv | 27 ++
 rtl/mul_share_arb.sv | 105 ++++++++++
 tb/tb_mul_share_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter.
package mul_share_arb_pkg;

  localparam int unsigned MUL_W    = 10;
  localparam int unsigned PROD_W   = 20;
  localparam int unsigned MAX_NREQ = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Out-of-range indices yield an all-zero vector.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx, input int unsigned n);
    return (idx < n) ? (MAX_NREQ'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, wrapping.
module mul_share_arb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   winner
);

  logic [PW-1:0] cand;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one external 10x10 signed multiplier; fixed 2-cycle grant-to-result latency.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*MUL_W-1:0]   a_in,
  input  logic [NREQ*MUL_W-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [MUL_W-1:0]        mul_a,
  output logic [MUL_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]       mul_q,
  output logic [NREQ-1:0]         res_valid,
  output logic [PROD_W-1:0]       res_q
);

  localparam int unsigned PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [MUL_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [PW-1:0]     s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [PROD_W-1:0] res_d;

  logic              any;
  logic [PW-1:0]     winner;
  logic              grant_en;
  logic [MAX_NREQ-1:0] win_oh, tag_oh;

  mul_share_arb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner)
  );

  assign mul_a = op_a_q;
  assign mul_b = op_b_q;

  always_comb begin
    grant_en  = any & ~stall & ~reset;
    win_oh    = onehot(32'(winner), NREQ);
    tag_oh    = onehot(32'(s2_tag_q), NREQ);
    gnt       = grant_en ? win_oh[NREQ-1:0] : '0;
    res_valid = (s2_valid_q & ~stall) ? tag_oh[NREQ-1:0] : '0;
  end

  // Stall freezes every stage; grant capture and result advance are otherwise independent.
  always_comb begin
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_tag_d   = s2_tag_q;
    res_d      = res_q;
    if (!stall) begin
      if (grant_en) begin
        op_a_d     = a_in[winner*MUL_W +: MUL_W];
        op_b_d     = b_in[winner*MUL_W +: MUL_W];
        s1_valid_d = 1'b1;
        s1_tag_d   = winner;
        ptr_d      = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end else begin
        s1_valid_d = 1'b0;
      end
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      if (s1_valid_q) begin
        res_d = mul_q;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ptr_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      res_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed table and sequences plus randomized traffic against a queue-based model.
module tb_mul_share_arb;

  localparam int N = 4;

  logic        sys_clk = 1'b0;
  logic        reset, stall;
  logic [3:0]  req;
  logic [39:0] a_in, b_in;
  logic [3:0]  gnt, res_valid;
  logic [9:0]  mul_a, mul_b;
  logic [19:0] mul_q, res_q;
  logic [19:0] ea, eb;

  always #5 sys_clk = ~sys_clk;

  // Shared multiplier: low 20 bits of sign-extended operands equal the exact signed product.
  assign ea    = {{10{mul_a[9]}}, mul_a};
  assign eb    = {{10{mul_b[9]}}, mul_b};
  assign mul_q = ea * eb;

  mul_share_arb #(.NREQ(N)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .stall     (stall),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_q     (mul_q),
    .res_valid (res_valid),
    .res_q     (res_q)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted op carries its age in unstalled edges; it is delivered at age 2.
  typedef struct {int age; int tag; int prod;} item_t;
  item_t pipe[$];
  int m_ptr, m_res, m_a, m_b, m_last_w;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int sop(input logic [39:0] v, input int i);
    logic signed [9:0] s;
    s = v[i*10 +: 10];
    return int'(s);
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*10 +: 10] = 10'(a);
    b_in[i*10 +: 10] = 10'(b);
  endtask

  task automatic cycle();
    int w, exp_rv;
    @(negedge sys_clk);
    w = (reset || stall) ? -1 : pick(req, m_ptr);
    exp_rv = 0;
    foreach (pipe[k]) if (pipe[k].age == 2 && !stall) exp_rv = 1 << pipe[k].tag;
    chk("model_gnt", 32'(gnt), (w < 0) ? 0 : (1 << w));
    chk("model_res_valid", 32'(res_valid), 32'(exp_rv));
    chk("model_mul_a", 32'(mul_a), 32'(m_a));
    chk("model_mul_b", 32'(mul_b), 32'(m_b));
    chk("model_res_q", {{12{res_q[19]}}, res_q}, 32'(m_res));
    @(posedge sys_clk);
    m_last_w = w;
    if (reset) begin
      pipe.delete();
      m_ptr = 0; m_res = 0; m_a = 0; m_b = 0;
    end else if (!stall) begin
      foreach (pipe[k]) pipe[k].age++;
      while (pipe.size() > 0 && pipe[0].age > 2) void'(pipe.pop_front());
      foreach (pipe[k]) if (pipe[k].age == 2) m_res = pipe[k].prod;
      if (w >= 0) begin
        pipe.push_back('{age: 1, tag: w, prod: sop(a_in, w) * sop(b_in, w)});
        m_ptr = (w + 1) % N;
        m_a   = int'(a_in[w*10 +: 10]);
        m_b   = int'(b_in[w*10 +: 10]);
      end
    end
    #1;
  endtask

  typedef struct {int a; int b; int exp_res;} vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{-512, -512, 262144};
    tbl[1] = '{511, -512, -261632};
    tbl[2] = '{0, -1, 0};
    tbl[3] = '{-1, -1, 1};
    tbl[4] = '{511, 511, 261121};

    reset = 1'b1; stall = 1'b0; req = '0; a_in = '0; b_in = '0;
    pipe.delete(); m_ptr = 0; m_res = 0; m_a = 0; m_b = 0; m_last_w = -1;
    repeat (2) @(posedge sys_clk);
    #1;
    cycle();
    reset = 1'b0;

    // Single request on requester 0
    req = 4'b0001; set_op(0, 3, -5);
    #2 chk("single_gnt", 32'(gnt), 32'h1);
    cycle();
    req = '0;
    #2 chk("single_mul_a", 32'(mul_a), 32'h3);
    chk("single_mul_b", 32'(mul_b), 32'h3FB);
    cycle();
    #2 chk("single_res_valid", 32'(res_valid), 32'h1);
    chk("single_res_q", 32'(res_q), 32'hFFFF1);
    cycle();

    // Extreme operand table on requester 2
    for (int i = 0; i < 5; i++) begin
      req = 4'b0100; set_op(2, tbl[i].a, tbl[i].b);
      cycle();
      req = '0;
      cycle();
      #2 chk("table_res_valid", 32'(res_valid), 32'h4);
      chk("table_res_q", {{12{res_q[19]}}, res_q}, 32'(tbl[i].exp_res));
      cycle();
    end

    // Fairness from ptr=0
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10 * (i + 1));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #2 chk("fair_gnt", 32'(gnt), 32'(1 << (i % 4)));
      if (i >= 2) chk("fair_res_valid", 32'(res_valid), 32'(1 << ((i - 2) % 4)));
      cycle();
    end
    req = '0; repeat (2) cycle();
    req = 4'b0010; cycle();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #2 chk("fair_alt_gnt", 32'(gnt), (i % 2 == 0) ? 32'h8 : 32'h2);
      cycle();
    end
    req = '0; repeat (3) cycle();

    // Stall holds a pending result, then releases it exactly once
    req = 4'b0010; set_op(1, 7, 9);
    #2 chk("stall_gnt", 32'(gnt), 32'h2);
    cycle();
    req = 4'b0011; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_gnt_off", 32'(gnt), 32'h0);
      chk("stall_res_valid_off", 32'(res_valid), 32'h0);
      chk("stall_mul_a", 32'(mul_a), 32'h7);
      chk("stall_mul_b", 32'(mul_b), 32'h9);
      cycle();
    end
    req = '0; stall = 1'b0;
    #2 chk("stall_release_t4", 32'(res_valid), 32'h0);
    cycle();
    #2 chk("stall_release_t5", 32'(res_valid), 32'h2);
    chk("stall_res_q", 32'(res_q), 32'd63);
    cycle();
    #2 chk("stall_release_t6", 32'(res_valid), 32'h0);
    cycle();

    // Reset mid-flight
    req = 4'b0001; set_op(0, 5, 5);
    #2 chk("rst_gnt", 32'(gnt), 32'h1);
    cycle();
    req = 4'b0011; reset = 1'b1;
    #2 chk("rst_gnt_masked", 32'(gnt), 32'h0);
    cycle();
    reset = 1'b0; req = '0;
    #2 chk("rst_res_valid_t2", 32'(res_valid), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_res_q", 32'(res_q), 32'h0);
    cycle();
    #2 chk("rst_res_valid_t3", 32'(res_valid), 32'h0);
    cycle();
    req = 4'b0101;
    #2 chk("rst_ptr_zero_gnt", 32'(gnt), 32'h1);
    cycle();
    req = '0; repeat (3) cycle();

    // Back-to-back on requester 3
    for (int c = 0; c < 7; c++) begin
      req = (c < 5) ? 4'b1000 : 4'b0000;
      set_op(3, c + 1, 2);
      if (c >= 2) begin
        #2 chk("b2b_res_valid", 32'(res_valid), 32'h8);
        chk("b2b_res_q", 32'(res_q), 32'(2 * (c - 1)));
      end
      cycle();
    end

    // Randomized traffic honouring the hold-until-granted protocol
    req = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom % 3 == 0)) begin
          req[i] = 1'b1;
          set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
      end
      stall = ($urandom % 7 == 0);
      reset = ($urandom % 50 == 0);
      cycle();
      if (m_last_w >= 0) req[m_last_w] = 1'b0;
    end
    stall = 1'b0; reset = 1'b0; req = '0;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
